// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle controller.
// Feature macro honoured by the controller: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
package multicycle_pkg;

    localparam int ALU_CTRL_WIDTH = 4;

    // Controller states; TRAP is only reachable when the trap macro is defined.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // ALU operation encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Supported opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // Operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Only beq and bne are implemented among the branches.
    function automatic logic branch_f3_ok(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decoder.sv
// ALU operation decoder: maps funct3/funct7_5 of an ALU instruction to an
// alu_control code and flags funct3 values this core does not implement.
module alu_op_decoder
    import multicycle_pkg::*;
(
    input  logic       i_is_rtype,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_alu_control,
    output logic       o_illegal
);

    // funct7_5 only selects SUB for register-register ops; addi ignores it.
    always_comb begin
        o_alu_control = ALU_ADD;
        o_illegal     = 1'b0;
        case (i_funct3)
            3'b000:  o_alu_control = (i_is_rtype && i_funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  o_alu_control = ALU_SLT;
            3'b110:  o_alu_control = ALU_OR;
            3'b111:  o_alu_control = ALU_AND;
            default: o_illegal     = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for an RV32I subset (lw, sw, R-ALU, I-ALU, beq,
// bne, jal). Moore outputs except the memory-handshake strobes in FETCH /
// MEMWRITE and pc_write in BRANCH.
// Optional macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: illegal instructions enter
// an absorbing TRAP state and set a sticky illegal_instr flag; otherwise they
// retire as NOPs and illegal_instr is tied low.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int ALU_CTRL_W = ALU_CTRL_WIDTH,
    parameter int STATE_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  instr_retired,
    output logic                  illegal_instr
);

    logic [STATE_W-1:0] r_state;
    state_t             w_state;
    state_t             w_next;
    logic [3:0]         w_alu;
    logic [3:0]         w_dec_alu;
    logic               w_dec_illegal;
    logic               w_take_illegal;

    assign w_state     = state_t'(r_state[3:0]);
    assign alu_control = ALU_CTRL_W'(w_alu);

    alu_op_decoder u_alu_dec (
        .i_is_rtype    (opcode == OP_R),
        .i_funct3      (funct3),
        .i_funct7_5    (funct7_5),
        .o_alu_control (w_dec_alu),
        .o_illegal     (w_dec_illegal)
    );

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) r_state <= STATE_W'(S_FETCH);
        else       r_state <= STATE_W'(w_next);
    end

    // Next-state and output decode; everything is forced low while in reset.
    always_comb begin
        w_next         = w_state;
        w_take_illegal = 1'b0;
        mem_req        = 1'b0;
        mem_write      = 1'b0;
        adr_src        = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        reg_write      = 1'b0;
        alu_src_a      = SRCA_PC;
        alu_src_b      = SRCB_RS2;
        result_src     = RES_ALUOUT;
        w_alu          = ALU_AND;
        instr_retired  = 1'b0;

        case (w_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                w_alu      = ALU_ADD;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jal target oldPC+imm lands in alu_out for later use.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                w_alu     = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R: begin
                        if (w_dec_illegal) w_take_illegal = 1'b1;
                        else               w_next = S_EXECR;
                    end
                    OP_I: begin
                        if (w_dec_illegal) w_take_illegal = 1'b1;
                        else               w_next = S_EXECI;
                    end
                    OP_BR: begin
                        if (branch_f3_ok(funct3)) w_next = S_BRANCH;
                        else                      w_take_illegal = 1'b1;
                    end
                    OP_JAL:  w_next = S_JAL;
                    default: w_take_illegal = 1'b1;
                endcase
                if (w_take_illegal) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_next        = S_FETCH;
                    instr_retired = 1'b1;
`endif
                end
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_alu     = ALU_ADD;
                w_next    = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = RES_MEMDATA;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    w_next        = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                w_alu     = w_dec_alu;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                w_alu     = w_dec_alu;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_BRANCH: begin
                // PC reloads from the target computed in DECODE.
                alu_src_a     = SRCA_RS1;
                alu_src_b     = SRCB_RS2;
                w_alu         = ALU_SUB;
                result_src    = RES_ALUOUT;
                pc_write      = (funct3 == F3_BEQ) ? zero : ~zero;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target; ALU forms the link value for ALUWB.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                w_alu      = ALU_ADD;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                w_next     = S_ALUWB;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase

        if (reset) begin
            mem_req        = 1'b0;
            mem_write      = 1'b0;
            adr_src        = 1'b0;
            ir_write       = 1'b0;
            pc_write       = 1'b0;
            reg_write      = 1'b0;
            alu_src_a      = SRCA_PC;
            alu_src_b      = SRCB_RS2;
            result_src     = RES_ALUOUT;
            w_alu          = ALU_AND;
            instr_retired  = 1'b0;
        end
    end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky flag set on the DECODE->TRAP transition, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)               r_illegal <= 1'b0;
        else if (w_take_illegal) r_illegal <= 1'b1;
    end

    assign illegal_instr = r_illegal & ~reset;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle scripts
// derived from the instruction semantics, random instruction mix and
// memory wait states, plus directed literal checks.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready, funct7_5;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_control;
    logic       instr_retired, illegal_instr;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_control(alu_control), .instr_retired(instr_retired),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    logic        m_illegal = 1'b0;
    bit          trapped = 1'b0;
    logic [17:0] hist[$];

    // Vector layout: mem_req mem_write adr_src ir_write pc_write reg_write
    //                a[1:0] b[1:0] res[1:0] alu[3:0] retired illegal
    function automatic logic [17:0] dut_vec();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_control, instr_retired,
                illegal_instr};
    endfunction

    function automatic logic [17:0] mk(logic mrq, logic mw, logic as, logic irw,
                                       logic pcw, logic rw, logic [1:0] a,
                                       logic [1:0] b, logic [1:0] r,
                                       logic [3:0] alu, logic ret);
        return {mrq, mw, as, irw, pcw, rw, a, b, r, alu, ret, m_illegal};
    endfunction

    function automatic bit legal(logic [6:0] op, logic [2:0] f3);
        case (op)
            LW, SW, JL: return 1'b1;
            RT, IT:     return (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
            BR:         return f3 < 3'd2;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] aluop(bit is_r, logic [2:0] f3, logic f75);
        case (f3)
            3'd0:    return (is_r && f75) ? A_SUB : A_ADD;
            3'd2:    return A_SLT;
            3'd6:    return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Cycles from first FETCH cycle to the retiring cycle, inclusive.
    function automatic int lat();
        foreach (hist[i]) if (hist[i][1]) return i + 1;
        return 0;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clock: apply inputs just after posedge, compare at negedge.
    task automatic step(input logic rst, input logic mr, input logic z,
                        input logic [17:0] exp, input string nm);
        logic [17:0] dv;
        reset = rst; mem_ready = mr; zero = z;
        @(negedge clk);
        dv = dut_vec();
        hist.push_back(dv);
        n_chk++;
        if (dv !== exp) begin
            n_fail++;
            $display("FAIL %s op=%b f3=%b: got %h expected %h", nm, opcode, funct3, dv, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        hist.delete();
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, rb(), 18'd0, "reset");
        m_illegal = 1'b0;
        trapped   = 1'b0;
    endtask

    task automatic trap_cycle();
        step(1'b0, rb(), rb(), mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,0), "trap");
    endtask

    // Drives one instruction from FETCH to retirement and checks every cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f75, input logic zbr,
                             input int wf, input int wm);
        bit ill;
        opcode = op; funct3 = f3; funct7_5 = f75;
        hist.delete();
        for (int i = 0; i < wf; i++)
            step(1'b0, 1'b0, rb(), mk(1,0,0,0,0,0,2'b00,2'b10,2'b10,A_ADD,0), "fetch_wait");
        step(1'b0, 1'b1, rb(), mk(1,0,0,1,1,0,2'b00,2'b10,2'b10,A_ADD,0), "fetch");
        ill = !legal(op, f3);
        step(1'b0, rb(), rb(), mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,A_ADD,ill && !TRAP_EN), "decode");
        if (ill) begin
            if (TRAP_EN) begin m_illegal = 1'b1; trapped = 1'b1; end
            return;
        end
        case (op)
            LW, SW: begin
                step(1'b0, rb(), rb(), mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,A_ADD,0), "memadr");
                for (int i = 0; i < wm; i++)
                    step(1'b0, 1'b0, rb(), mk(1,op==SW,1,0,0,0,2'd0,2'd0,2'd0,4'd0,0), "mem_wait");
                step(1'b0, 1'b1, rb(), mk(1,op==SW,1,0,0,0,2'd0,2'd0,2'd0,4'd0,op==SW), "mem");
                if (op == LW)
                    step(1'b0, rb(), rb(), mk(0,0,0,0,0,1,2'd0,2'd0,2'b01,4'd0,1), "memwb");
            end
            RT, IT: begin
                step(1'b0, rb(), rb(), mk(0,0,0,0,0,0,2'b10,(op==RT)?2'b00:2'b01,2'b00,
                                          aluop(op==RT,f3,f75),0), "exec");
                step(1'b0, rb(), rb(), mk(0,0,0,0,0,1,2'd0,2'd0,2'b00,4'd0,1), "aluwb");
            end
            BR: begin
                step(1'b0, rb(), zbr, mk(0,0,0,0,(f3==3'd0)?zbr:!zbr,0,2'b10,2'b00,2'b00,A_SUB,1),
                     "branch");
            end
            default: begin
                step(1'b0, rb(), rb(), mk(0,0,0,0,1,0,2'b01,2'b10,2'b00,A_ADD,0), "jal");
                step(1'b0, rb(), rb(), mk(0,0,0,0,0,1,2'd0,2'd0,2'b00,4'd0,1), "aluwb");
            end
        endcase
    endtask

    initial begin
        int c_adr, c_wb, c_ret;
        logic [6:0] rop;
        logic [2:0] rf3;
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
        @(posedge clk); #1;

        // Reset held two cycles: all outputs low.
        do_reset(2);
        check("reset_outputs_zero", int'(hist[1]), 0);

        // R-type sub; its first cycle is also the first fetch after reset.
        run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
        check("first_fetch_mem_req", int'(hist[0][17]), 1);
        check("first_fetch_ir_write", int'(hist[0][14]), 1);
        check("first_fetch_pc_write", int'(hist[0][13]), 1);
        check("first_fetch_alu", int'(hist[0][5:2]), 4'b0010);
        check("first_fetch_src_b", int'(hist[0][9:8]), 2'b10);
        check("sub_execr_alu", int'(hist[2][5:2]), 4'b0110);
        check("sub_aluwb_reg_write", int'(hist[3][12]), 1);
        check("sub_latency", lat(), 4);

        // lw with three wait cycles in MEMREAD.
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 3);
        c_adr = 0; c_wb = 0; c_ret = 0;
        foreach (hist[i]) begin
            if (hist[i][17] && hist[i][15]) c_adr++;
            if (hist[i][12] && hist[i][7:6] == 2'b01) c_wb++;
            if (hist[i][1]) c_ret++;
        end
        check("lw_latency", lat(), 8);
        check("lw_memread_cycles", c_adr, 4);
        check("lw_writeback_count", c_wb, 1);
        check("lw_retire_count", c_ret, 1);

        run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 0);
        check("sw_latency", lat(), 4);

        run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0);
        check("beq_taken_pc_write", int'(hist[2][13]), 1);
        check("beq_latency", lat(), 3);
        run_instr(BR, 3'b001, 1'b0, 1'b1, 0, 0);
        check("bne_not_taken_pc_write", int'(hist[2][13]), 0);
        check("bne_latency", lat(), 3);

        run_instr(JL, 3'b000, 1'b0, 1'b0, 0, 0);
        c_ret = 0;
        foreach (hist[i]) if (hist[i][1]) c_ret++;
        check("jal_pc_write", int'(hist[2][13]), 1);
        check("jal_src_a", int'(hist[2][11:10]), 2'b01);
        check("jal_src_b", int'(hist[2][9:8]), 2'b10);
        check("jal_link_reg_write", int'(hist[3][12]), 1);
        check("jal_retire_count", c_ret, 1);
        check("jal_latency", lat(), 4);

        // Opcode 0000000 is unsupported.
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) trap_cycle();
        check("trap_illegal_sticky", int'(hist[$][0]), 1);
        check("trap_outputs_quiet", int'(hist[$][17:1]), 0);
        do_reset(1);
        check("trap_cleared_by_reset", int'(illegal_instr), 0);
`else
        check("nop_retired_in_decode", int'(hist[1][1]), 1);
        run_instr(IT, 3'b110, 1'b0, 1'b0, 0, 0);
        check("nop_next_is_fetch", int'(hist[0][17]), 1);
        check("nop_illegal_low", int'(hist[0][0]), 0);
`endif

        // Random instruction mix with random wait states.
        for (int n = 0; n < 250; n++) begin
            if (trapped) begin
                for (int i = 0; i < 3; i++) trap_cycle();
                do_reset(1 + int'($urandom_range(0, 1)));
            end
            case ($urandom_range(0, 6))
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = IT;
                4: rop = BR;
                5: rop = JL;
                default: begin
                    rop = 7'($urandom_range(0, 127));
                    while (legal(rop, 3'd0)) rop = 7'($urandom_range(0, 127));
                end
            endcase
            rf3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (rop == BR) rf3 = 3'($urandom_range(0, 1));
                else if (rop == RT || rop == IT) begin
                    case ($urandom_range(0, 3))
                        0: rf3 = 3'd0;
                        1: rf3 = 3'd2;
                        2: rf3 = 3'd6;
                        default: rf3 = 3'd7;
                    endcase
                end
            end
            run_instr(rop, rf3, rb(), rb(),
                      rb() ? 0 : int'($urandom_range(1, 3)),
                      rb() ? 0 : int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
